// File: rtl/program_loader_pkg.sv
// Shared CPU-side constants and loader state encoding.
// Used by the program loader and by anything that sizes the instruction image.
package program_loader_pkg;

    localparam int NUM_WORDS = 32;
    localparam int WORD_W    = 32;
    localparam int COUNT_W   = 6;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        RUN   = 2'd2
    } loader_state_t;

endpackage

// File: rtl/program_loader.sv
// Streams a program image into a word store that feeds the CPU memory inputs,
// holding the CPU in reset until the image is complete and stable.
module program_loader #(
    parameter int NUM_WORDS = program_loader_pkg::NUM_WORDS,
    parameter int WORD_W    = program_loader_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              reload,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    input  logic              wr_last,
    output logic              wr_ready,
    output logic [WORD_W-1:0] in0,
    output logic [WORD_W-1:0] in1,
    output logic [WORD_W-1:0] in2,
    output logic [WORD_W-1:0] in3,
    output logic [WORD_W-1:0] in4,
    output logic [WORD_W-1:0] in5,
    output logic [WORD_W-1:0] in6,
    output logic [WORD_W-1:0] in7,
    output logic [WORD_W-1:0] in8,
    output logic [WORD_W-1:0] in9,
    output logic [WORD_W-1:0] in10,
    output logic [WORD_W-1:0] in11,
    output logic [WORD_W-1:0] in12,
    output logic [WORD_W-1:0] in13,
    output logic [WORD_W-1:0] in14,
    output logic [WORD_W-1:0] in15,
    output logic [WORD_W-1:0] in16,
    output logic [WORD_W-1:0] in17,
    output logic [WORD_W-1:0] in18,
    output logic [WORD_W-1:0] in19,
    output logic [WORD_W-1:0] in20,
    output logic [WORD_W-1:0] in21,
    output logic [WORD_W-1:0] in22,
    output logic [WORD_W-1:0] in23,
    output logic [WORD_W-1:0] in24,
    output logic [WORD_W-1:0] in25,
    output logic [WORD_W-1:0] in26,
    output logic [WORD_W-1:0] in27,
    output logic [WORD_W-1:0] in28,
    output logic [WORD_W-1:0] in29,
    output logic [WORD_W-1:0] in30,
    output logic [WORD_W-1:0] in31,
    output logic              cpu_reset,
    output logic [5:0]        load_count
);
    import program_loader_pkg::*;

    localparam int IDX_W = $clog2(NUM_WORDS);

    loader_state_t     state_reg;
    logic [WORD_W-1:0] word_reg [NUM_WORDS];
    logic [5:0]        load_count_reg;
    logic              cpu_reset_reg;
    logic              wr_ready_reg;

    // Words are only ever written in ascending order after a full clear, so
    // anything beyond an early wr_last is already zero.
    always_ff @(posedge clk) begin
        if (reset || reload) begin
            state_reg      <= LOAD;
            load_count_reg <= '0;
            cpu_reset_reg  <= 1'b1;
            wr_ready_reg   <= 1'b1;
            for (int i = 0; i < NUM_WORDS; i++) begin
                word_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                LOAD: begin
                    if (wr_valid && wr_ready_reg) begin
                        word_reg[load_count_reg[IDX_W-1:0]] <= wr_data;
                        load_count_reg <= load_count_reg + 6'd1;
                        if (wr_last || load_count_reg == 6'(NUM_WORDS - 1)) begin
                            state_reg    <= FLUSH;
                            wr_ready_reg <= 1'b0;
                        end
                    end
                end
                FLUSH: begin
                    state_reg     <= RUN;
                    cpu_reset_reg <= 1'b0;
                end
                RUN: begin
                    state_reg <= RUN;
                end
                default: begin
                    state_reg     <= LOAD;
                    cpu_reset_reg <= 1'b1;
                    wr_ready_reg  <= 1'b1;
                end
            endcase
        end
    end

    assign wr_ready   = wr_ready_reg;
    assign cpu_reset  = cpu_reset_reg;
    assign load_count = load_count_reg;

    assign in0  = word_reg[0];
    assign in1  = word_reg[1];
    assign in2  = word_reg[2];
    assign in3  = word_reg[3];
    assign in4  = word_reg[4];
    assign in5  = word_reg[5];
    assign in6  = word_reg[6];
    assign in7  = word_reg[7];
    assign in8  = word_reg[8];
    assign in9  = word_reg[9];
    assign in10 = word_reg[10];
    assign in11 = word_reg[11];
    assign in12 = word_reg[12];
    assign in13 = word_reg[13];
    assign in14 = word_reg[14];
    assign in15 = word_reg[15];
    assign in16 = word_reg[16];
    assign in17 = word_reg[17];
    assign in18 = word_reg[18];
    assign in19 = word_reg[19];
    assign in20 = word_reg[20];
    assign in21 = word_reg[21];
    assign in22 = word_reg[22];
    assign in23 = word_reg[23];
    assign in24 = word_reg[24];
    assign in25 = word_reg[25];
    assign in26 = word_reg[26];
    assign in27 = word_reg[27];
    assign in28 = word_reg[28];
    assign in29 = word_reg[29];
    assign in30 = word_reg[30];
    assign in31 = word_reg[31];

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full/early loads, gaps, reload, reset.
module tb_program_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        reload;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        wr_ready;
    logic        cpu_reset;
    logic [5:0]  load_count;
    logic [31:0] img [32];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    program_loader dut (
        .clk(clk), .reset(reset), .reload(reload),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_ready(wr_ready),
        .in0(img[0]),   .in1(img[1]),   .in2(img[2]),   .in3(img[3]),
        .in4(img[4]),   .in5(img[5]),   .in6(img[6]),   .in7(img[7]),
        .in8(img[8]),   .in9(img[9]),   .in10(img[10]), .in11(img[11]),
        .in12(img[12]), .in13(img[13]), .in14(img[14]), .in15(img[15]),
        .in16(img[16]), .in17(img[17]), .in18(img[18]), .in19(img[19]),
        .in20(img[20]), .in21(img[21]), .in22(img[22]), .in23(img[23]),
        .in24(img[24]), .in25(img[25]), .in26(img[26]), .in27(img[27]),
        .in28(img[28]), .in29(img[29]), .in30(img[30]), .in31(img[31]),
        .cpu_reset(cpu_reset), .load_count(load_count)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) begin
            $display("check %-20s observed=%h expected=%h ok", tag, observed, expected);
        end else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
            $error("check %s did not match", tag);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count of non-zero words from index lo upward.
    function automatic int nonzero_from(input int lo);
        int n = 0;
        for (int i = lo; i < 32; i++) if (img[i] !== 32'h0) n++;
        return n;
    endfunction

    task automatic beat(input logic [31:0] d, input logic last);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_last  = last;
        step();
        wr_valid = 1'b0;
        wr_last  = 1'b0;
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        step();
        reload = 1'b0;
    endtask

    initial begin
        reset = 1'b1; reload = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        step(); step();
        reset = 1'b0;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_wr_ready", 32'(wr_ready), 32'd1);
        check("rst_load_count", 32'(load_count), 32'd0);
        check("rst_all_zero", nonzero_from(0), 0);

        // Full load of 32 beats, no wr_last.
        for (int k = 0; k < 32; k++) beat(32'h100 + k, 1'b0);
        check("full_in5", img[5], 32'h105);
        check("full_in31", img[31], 32'h11F);
        check("full_count", 32'(load_count), 32'd32);
        check("full_flush_cpu_rst", 32'(cpu_reset), 32'd1);
        check("full_flush_ready", 32'(wr_ready), 32'd0);
        step();
        check("full_run_cpu_rst", 32'(cpu_reset), 32'd0);

        // Reload from RUN.
        pulse_reload();
        check("rl_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rl_all_zero", nonzero_from(0), 0);
        check("rl_count", 32'(load_count), 32'd0);
        check("rl_wr_ready", 32'(wr_ready), 32'd1);

        // Early wr_last on the third beat.
        beat(32'h08C40010, 1'b0);
        beat(32'h40030008, 1'b0);
        beat(32'h40030008, 1'b1);
        check("early_in0", img[0], 32'h08C40010);
        check("early_in1", img[1], 32'h40030008);
        check("early_in2", img[2], 32'h40030008);
        check("early_count", 32'(load_count), 32'd3);
        check("early_flush_cpu_rst", 32'(cpu_reset), 32'd1);
        step();
        check("early_run_cpu_rst", 32'(cpu_reset), 32'd0);
        check("early_zero_fill", nonzero_from(3), 0);

        // Gaps: valid every other cycle, garbage data while invalid.
        pulse_reload();
        for (int k = 0; k < 8; k++) begin
            wr_valid = (k % 2 == 0);
            wr_data  = (k % 2 == 0) ? 32'hA0 + k : 32'hBAD0 + k;
            step();
        end
        wr_valid = 1'b0;
        step(); step();
        check("gap_count", 32'(load_count), 32'd4);
        check("gap_cpu_rst_idle", 32'(cpu_reset), 32'd1);
        check("gap_in0", img[0], 32'hA0);
        check("gap_in1", img[1], 32'hA2);
        check("gap_in2", img[2], 32'hA4);
        check("gap_in3", img[3], 32'hA6);
        check("gap_in4", img[4], 32'h0);
        beat(32'hA8, 1'b1);
        step();
        wr_valid = 1'b1; wr_data = 32'hDEADBEEF;
        #1;
        check("run_wr_ready", 32'(wr_ready), 32'd0);
        step(); step();
        wr_valid = 1'b0;
        check("run_count_hold", 32'(load_count), 32'd5);
        check("run_in4_hold", img[4], 32'hA8);
        check("run_in5_hold", img[5], 32'h0);
        check("run_cpu_rst", 32'(cpu_reset), 32'd0);

        // Reload colliding with an accepted beat at load_count=7.
        pulse_reload();
        for (int k = 0; k < 7; k++) beat(32'h200 + k, 1'b0);
        check("coll_pre_count", 32'(load_count), 32'd7);
        wr_valid = 1'b1; wr_data = 32'h207; reload = 1'b1;
        step();
        wr_valid = 1'b0; reload = 1'b0;
        check("coll_count", 32'(load_count), 32'd0);
        check("coll_in7", img[7], 32'h0);
        check("coll_all_zero", nonzero_from(0), 0);
        check("coll_cpu_rst", 32'(cpu_reset), 32'd1);

        // Reset mid-load at load_count=10, overriding a beat.
        for (int k = 0; k < 10; k++) beat(32'h300 + k, 1'b0);
        check("mid_pre_count", 32'(load_count), 32'd10);
        reset = 1'b1; wr_valid = 1'b1; wr_data = 32'h30A;
        step();
        reset = 1'b0; wr_valid = 1'b0;
        check("mid_count", 32'(load_count), 32'd0);
        check("mid_all_zero", nonzero_from(0), 0);
        check("mid_cpu_rst", 32'(cpu_reset), 32'd1);
        check("mid_wr_ready", 32'(wr_ready), 32'd1);
        beat(32'h55, 1'b0);
        check("mid_after_in0", img[0], 32'h55);
        check("mid_after_count", 32'(load_count), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
